// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

    localparam int BUF_DEPTH      = 3;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int OCC_W = clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_reader_rd_buf.sv
// Small in-order register FIFO; the head always sits in entry 0 so it holds still until popped.
module fifo_rd_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [OCC_W-1:0] o_occ,
    output logic [W-1:0]     o_head
);

    logic [W-1:0]     r_mem [0:BUF_DEPTH-1];
    logic [OCC_W-1:0] r_occ;
    logic [W-1:0]     w_mem_nxt [0:BUF_DEPTH-1];
    logic [OCC_W-1:0] w_occ_nxt;
    logic [OCC_W-1:0] w_wr_idx;

    // Next-state: shift toward the head on pop, then write at the tail slot after the shift.
    always_comb begin
        w_mem_nxt = r_mem;
        w_occ_nxt = r_occ;
        if (i_pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_occ_nxt = r_occ - {{(OCC_W-1){1'b0}}, 1'b1};
            w_wr_idx  = r_occ - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            w_wr_idx  = r_occ;
        end
        if (i_push) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (OCC_W'(i) == w_wr_idx) begin
                    w_mem_nxt[i] = i_data;
                end else begin
                    w_mem_nxt[i] = w_mem_nxt[i];
                end
            end
            w_occ_nxt = w_occ_nxt + {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            w_occ_nxt = w_occ_nxt;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_occ <= {OCC_W{1'b0}};
        end else begin
            r_mem <= w_mem_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream with frame-end tags at full rate.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int FCNT_W = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

    logic                  r_run;
    logic                  r_pending;
    logic [FCNT_W-1:0]     r_fcnt_tail;
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic [OCC_W-1:0]      w_occ;
    logic [DATA_WIDTH:0]   w_head;
    logic [OCC_W:0]        w_fill;
    logic                  w_tag;
    logic                  w_pop;

    // Credits count words already buffered plus the one in flight, so the buffer can never overflow.
    assign w_fill     = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_pending};
    assign fifo_rd_en = r_run && !fifo_empty && (w_fill < (OCC_W+1)'(BUF_DEPTH));
    assign w_tag      = (r_fcnt_tail == FCNT_LAST);
    assign m_valid    = (w_occ != {OCC_W{1'b0}});
    assign m_data     = w_head[DATA_WIDTH-1:0];
    assign m_last     = w_head[DATA_WIDTH];
    assign w_pop      = m_valid && m_ready;
    assign word_count = r_word_count;

    fifo_rd_buf #(.W(DATA_WIDTH + 1)) u_buf (
        .clk    (rd_clk),
        .rst    (rst),
        .i_push (r_pending),
        .i_data ({w_tag, fifo_dout}),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (w_head)
    );

    // Read-issue tracking, frame position of the next pushed word, and delivered-word count.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_run        <= 1'b0;
            r_pending    <= 1'b0;
            r_fcnt_tail  <= {FCNT_W{1'b0}};
            r_word_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_run     <= 1'b1;
            r_pending <= fifo_rd_en;
            if (r_pending) begin
                r_fcnt_tail <= w_tag ? {FCNT_W{1'b0}} : r_fcnt_tail + {{(FCNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_fcnt_tail <= r_fcnt_tail;
            end
            if (w_pop) begin
                r_word_count <= r_word_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_word_count <= r_word_count;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural FIFO model feeding the reader, plus an in-order scoreboard.
module tb_fifo_stream_reader;

    logic        rd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] word_count;

    logic        rd_en4, m_valid4, m_last4;
    logic [7:0]  m_data4;
    logic [3:0]  word_count4;

    logic [7:0]  mem [0:511];
    logic [8:0]  wr_ptr = 9'd0;
    logic [8:0]  rd_ptr = 9'd0;

    logic [8:0]  sb_idx = 9'd0;
    int          sb_pos = 0;
    logic [15:0] sb_cnt = 16'd0;
    int          last_cnt = 0;
    bit          sb_en = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int cur_run, best_run, tot_valid;

    fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .word_count(word_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .FRAME_LEN(16), .CNT_WIDTH(4)) dut4 (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_en4), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .m_last(m_last4), .word_count(word_count4)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model with one-cycle registered read data.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 9'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 9'd1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb_idx != wr_ptr && k < 300) begin
            tick();
            k++;
        end
        check_eq(tag, {23'd0, sb_idx}, {23'd0, wr_ptr});
    endtask

    // Scoreboard: head must match the next expected word; words lost in a reset are skipped.
    always @(negedge rd_clk) begin
        if (sb_en) begin
            if (rst) begin
                sb_idx = rd_ptr;
                sb_pos = 0;
                sb_cnt = 16'd0;
            end else begin
                check_eq("word_count", {16'd0, word_count}, {16'd0, sb_cnt});
                check_eq("word_count4", {28'd0, word_count4}, {28'd0, sb_cnt[3:0]});
                if (fifo_empty) begin
                    check_eq("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
                end
                if (m_valid) begin
                    check_eq("m_data", {24'd0, m_data}, {24'd0, mem[sb_idx]});
                    check_eq("m_last", {31'd0, m_last}, {31'd0, (sb_pos == 15)});
                    if (m_ready) begin
                        if (m_last) last_cnt++;
                        sb_idx = sb_idx + 9'd1;
                        sb_pos = (sb_pos + 1) % 16;
                        sb_cnt = sb_cnt + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        // Reset with a word already waiting in the FIFO
        push_word(8'hA5);
        sb_en = 1'b1;
        repeat (3) tick();
        @(negedge rd_clk);
        check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_m_data", {24'd0, m_data}, 32'd0);
        check_eq("rst_m_last", {31'd0, m_last}, 32'd0);
        check_eq("rst_word_count", {16'd0, word_count}, 32'd0);

        // Latency: rd_en in cycle N, word visible in N+2
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        @(negedge rd_clk);
        check_eq("lat_rd_en_N", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        @(negedge rd_clk);
        check_eq("lat_valid_N1", {31'd0, m_valid}, 32'd0);
        tick();
        @(negedge rd_clk);
        check_eq("lat_valid_N2", {31'd0, m_valid}, 32'd1);
        check_eq("lat_data_N2", {24'd0, m_data}, 32'h0000_00A5);
        tick();
        @(negedge rd_clk);
        check_eq("lat_count", {16'd0, word_count}, 32'd1);
        check_eq("lat_valid_after", {31'd0, m_valid}, 32'd0);

        // Throughput: 64 words back to back, frame tags every 16th word
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) push_word(8'(i));
        last_cnt = 0;
        rst = 1'b0;
        cur_run = 0; best_run = 0; tot_valid = 0;
        repeat (80) begin
            @(negedge rd_clk);
            if (m_valid) begin
                cur_run++;
                tot_valid++;
                if (cur_run > best_run) best_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
        check_eq("tput_run", best_run, 32'd64);
        check_eq("tput_total", tot_valid, 32'd64);
        check_eq("tput_last_cnt", last_cnt, 32'd4);
        check_eq("tput_count", {16'd0, word_count}, 32'd64);
        check_eq("tput_drained", {23'd0, sb_idx}, {23'd0, wr_ptr});

        // Backpressure: stall mid-stream until the buffer saturates
        tick();
        for (int i = 0; i < 40; i++) push_word(8'h40 + 8'(i));
        repeat (10) tick();
        m_ready = 1'b0;
        repeat (10) tick();
        @(negedge rd_clk);
        check_eq("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("bp_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
        check_eq("bp_valid", {31'd0, m_valid}, 32'd1);
        check_eq("bp_occ", {23'd0, rd_ptr - sb_idx}, 32'd3);
        tick();
        m_ready = 1'b1;
        drain("bp_drain");
        check_eq("bp_count", {16'd0, word_count}, 32'd104);

        // Empty edges: FIFO empties while the read is in flight
        m_ready = 1'b0;
        tick();
        push_word(8'hC1);
        @(negedge rd_clk);
        check_eq("emp_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        @(negedge rd_clk);
        check_eq("emp_empty", {31'd0, fifo_empty}, 32'd1);
        check_eq("emp_valid_pend", {31'd0, m_valid}, 32'd0);
        tick();
        @(negedge rd_clk);
        check_eq("emp_valid", {31'd0, m_valid}, 32'd1);
        check_eq("emp_data", {24'd0, m_data}, 32'h0000_00C1);
        tick();
        push_word(8'hC2);
        repeat (4) tick();
        @(negedge rd_clk);
        check_eq("emp_occ2", {23'd0, rd_ptr - sb_idx}, 32'd2);
        tick();
        m_ready = 1'b1;
        @(negedge rd_clk);
        check_eq("emp_drain0", {31'd0, m_valid}, 32'd1);
        tick();
        @(negedge rd_clk);
        check_eq("emp_drain1", {31'd0, m_valid}, 32'd1);
        tick();
        @(negedge rd_clk);
        check_eq("emp_drain2", {31'd0, m_valid}, 32'd0);

        // Counter wrap with a 4-bit counter
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) push_word(8'hD0 + 8'(i));
        drain("wrap_drain");
        @(negedge rd_clk);
        check_eq("wrap_count16", {16'd0, word_count}, 32'd17);
        check_eq("wrap_count4", {28'd0, word_count4}, 32'd1);

        // Reset while two words are buffered
        tick();
        m_ready = 1'b0;
        push_word(8'hF0);
        push_word(8'hF1);
        repeat (5) tick();
        @(negedge rd_clk);
        check_eq("rst2_occ", {23'd0, rd_ptr - sb_idx}, 32'd2);
        tick();
        rst = 1'b1;
        @(negedge rd_clk);
        check_eq("rst2_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst2_data", {24'd0, m_data}, 32'd0);
        check_eq("rst2_last", {31'd0, m_last}, 32'd0);
        check_eq("rst2_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("rst2_count", {16'd0, word_count}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (8) begin
            @(negedge rd_clk);
            check_eq("rst2_no_stale", {31'd0, m_valid}, 32'd0);
        end
        tick();
        push_word(8'hE7);
        drain("rst2_drain");
        @(negedge rd_clk);
        check_eq("rst2_final_count", {16'd0, word_count}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
